// File: rtl/onehot_req_scheduler.sv
// Round-robin scheduler turning edge-detected request events into a registered one-hot grant with ack/timeout.
// Define ONEHOT_REQ_SYNC_EN to pass req through a two-flop synchronizer before edge detection.
module onehot_req_scheduler #(
  parameter int TMO = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       ack,
  output logic       I0,
  output logic       I1,
  output logic       I2,
  output logic       I3,
  output logic       valid,
  output logic [3:0] pending,
  output logic       tmo_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [3:0] TMO_LAST = 4'(TMO - 1);

  logic [3:0] req_s;
  logic [3:0] req_q;
  logic [3:0] rise;

`ifdef ONEHOT_REQ_SYNC_EN
  logic [3:0] sync1;
  logic [3:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= req;
      sync2 <= sync1;
    end
  end

  assign req_s = sync2;
`else
  assign req_s = req;
`endif

  assign rise = req_s & ~req_q;

  logic [1:0] state;
  logic [1:0] ptr;
  logic [1:0] gsel;
  logic [1:0] pick;
  logic       pick_any;
  logic [3:0] grant;
  logic [3:0] cnt;
  logic [3:0] clr;

  // Search ptr+1, ptr+2, ... wrapping mod 4; the fourth probe lands back on ptr itself.
  // NOTE: pick/pick_any get defaults before the loop so no path leaves them unassigned (no latch).
  always_comb begin
    pick     = ptr;
    pick_any = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!pick_any && pending[ptr + 2'(i)]) begin
        pick     = ptr + 2'(i);
        pick_any = 1'b1;
      end
    end
  end

  assign clr = (state == GRANT && ack) ? grant : 4'b0000;

  // NOTE: every register here uses <= so all of them see the pre-edge values of each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'd3;
      gsel    <= 2'd0;
      grant   <= 4'b0000;
      valid   <= 1'b0;
      cnt     <= 4'd0;
      tmo_err <= 1'b0;
      pending <= 4'b0000;
      req_q   <= 4'b0000;
    end else begin
      req_q   <= req_s;
      tmo_err <= 1'b0;
      // A rise on the channel being acked in this cycle survives the clear.
      pending <= (pending & ~clr) | rise;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state <= GRANT;
            gsel  <= pick;
            grant <= 4'b0001 << pick;
            valid <= 1'b1;
            cnt   <= 4'd0;
          end
        end
        GRANT: begin
          if (ack || cnt == TMO_LAST) begin
            state   <= GAP;
            ptr     <= gsel;
            grant   <= 4'b0000;
            valid   <= 1'b0;
            tmo_err <= !ack;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign I0 = grant[0];
  assign I1 = grant[1];
  assign I2 = grant[2];
  assign I3 = grant[3];

endmodule
